max_tree_in_packer: RTL and testbench

Stream-to-vector packer that feeds the pipelined signed max-compare tree. It accepts one signed element per beat from a valid/ready stream and groups beats into pooling-window vectors of up to `cmp_input_n` lanes. Each completed vector is presented on the tree's `cmp_in`/`cmp_in_vld` input, with unused lanes padded with the most-negative value. It shares the tree's global clock enable, so the two blocks stall together.

---
 rtl/max_tree_in_packer.sv | 142 ++++++++++++++
 tb/tb_max_tree_in_packer.sv | 239 +++++++++++++++++++++++
 2 files changed

// File: rtl/max_tree_in_packer.sv
`default_nettype none
// ============================================================================
// Module   : max_tree_in_packer
// Purpose  : Packs a valid/ready element stream into pooling-window vectors
//            for the pipelined signed max-compare tree. Each vector holds up
//            to cmp_input_n lanes. Lanes not filled by the window are padded
//            with the most-negative signed value, so they can never win a max.
//            The block shares the tree's global clock enable, so the two
//            stall together.
// Ports    : aclk, aresetn      - clock, synchronous active-low reset
//            aclken             - global clock enable (qualifies all updates)
//            win_len[5:0]       - elements per vector (0 or >N means N)
//            s_axis_data/last/valid, s_axis_ready - input element stream
//            cmp_in             - packed vector; lane k in [(k+1)*W-1 : k*W]
//            cmp_in_vld         - vector valid towards the tree
//            cmp_in_last        - vector was closed by s_axis_last
//            vec_cnt[15:0]      - wrapping count of emitted vectors
// Revision : 1.0 - initial release
// ============================================================================
module max_tree_in_packer #(
  parameter int cmp_input_n      = 4,
  parameter int cmp_width        = 8,
  parameter int simulation_delay = 1
) (
  input  logic                              aclk,
  input  logic                              aresetn,
  input  logic                              aclken,
  input  logic [5:0]                        win_len,
  input  logic [cmp_width-1:0]              s_axis_data,
  input  logic                              s_axis_last,
  input  logic                              s_axis_valid,
  output logic                              s_axis_ready,
  output logic [cmp_input_n*cmp_width-1:0]  cmp_in,
  output logic                              cmp_in_vld,
  output logic                              cmp_in_last,
  output logic [15:0]                       vec_cnt
);

  localparam int                   c_cnt_w = $clog2(cmp_input_n);
  localparam logic [5:0]           c_n     = 6'(cmp_input_n);
  localparam logic [cmp_width-1:0] c_pad   = {1'b1, {(cmp_width-1){1'b0}}};

  // Register updates are modelled with zero delay; the delay parameter is
  // kept only so that instantiations written for the original interface
  // still elaborate unchanged.
  if (simulation_delay > 0) begin : g_sim_delay
  end else begin : g_no_sim_delay
  end

  // --------------------------------------------------------------------------
  // State
  // --------------------------------------------------------------------------
  logic [c_cnt_w-1:0]               r_cnt;
  logic [5:0]                       r_len;
  logic [cmp_width-1:0]             r_buf [cmp_input_n];
  logic [cmp_input_n*cmp_width-1:0] r_cmp_in;
  logic                             r_vld;
  logic                             r_last;
  logic [15:0]                      r_vec_cnt;

  // --------------------------------------------------------------------------
  // Combinational control
  // --------------------------------------------------------------------------
  logic [5:0]                       w_win_clamped;
  logic [5:0]                       w_len_eff;
  logic [5:0]                       w_cnt_ext;
  logic                             w_accept;
  logic                             w_done;
  logic [cmp_input_n*cmp_width-1:0] w_vec;

  assign s_axis_ready = aclken;
  assign w_accept     = s_axis_valid & aclken;

  assign w_win_clamped = ((win_len == 6'd0) || (win_len > c_n)) ? c_n : win_len;

  // At a vector start the live win_len is used directly, so a one-beat
  // window completes on its very first beat; afterwards the latched copy
  // keeps mid-vector win_len changes from affecting the current vector.
  assign w_len_eff = (r_cnt == '0) ? w_win_clamped : r_len;
  assign w_cnt_ext = 6'(r_cnt);

  assign w_done = w_accept &
                  ((w_cnt_ext == (w_len_eff - 6'd1)) | s_axis_last);

  // Assemble the completed vector: earlier lanes from the buffer, the
  // current lane straight from the bus, remaining lanes padded.
  for (genvar k = 0; k < cmp_input_n; k++) begin : g_lane
    localparam logic [5:0] c_k = 6'(k);
    assign w_vec[k*cmp_width +: cmp_width] =
        (c_k <  w_cnt_ext) ? r_buf[k]    :
        (c_k == w_cnt_ext) ? s_axis_data :
                             c_pad;
  end

  // --------------------------------------------------------------------------
  // Fill counter, active length and output register
  // --------------------------------------------------------------------------
  always_ff @(posedge aclk) begin
    if (!aresetn) begin
      r_cnt     <= '0;
      r_len     <= c_n;
      r_cmp_in  <= {cmp_input_n{c_pad}};
      r_vld     <= 1'b0;
      r_last    <= 1'b0;
      r_vec_cnt <= 16'd0;
    end else if (aclken) begin
      if (w_accept && (r_cnt == '0)) begin
        r_len <= w_win_clamped;
      end

      if (w_done) begin
        r_cmp_in  <= w_vec;
        r_vld     <= 1'b1;
        r_last    <= s_axis_last;
        r_vec_cnt <= r_vec_cnt + 16'd1;
        r_cnt     <= '0;
      end else begin
        // cmp_in is left untouched so the tree keeps a stable operand.
        r_vld  <= 1'b0;
        r_last <= 1'b0;
        if (w_accept) begin
          r_cnt <= r_cnt + 1'b1;
        end
      end
    end
  end

  // The accumulation buffer needs no reset: a lane is always written before
  // the output mux can select it, and stale lanes are replaced by padding.
  always_ff @(posedge aclk) begin
    if (aresetn && w_accept) begin
      r_buf[r_cnt] <= s_axis_data;
    end
  end

  assign cmp_in      = r_cmp_in;
  assign cmp_in_vld  = r_vld;
  assign cmp_in_last = r_last;
  assign vec_cnt     = r_vec_cnt;

endmodule
`default_nettype wire

// File: tb/tb_max_tree_in_packer.sv
`default_nettype none
// ============================================================================
// Module   : tb_max_tree_in_packer
// Purpose  : Self-checking bench for max_tree_in_packer (N=4, W=8). A queue
//            model of the window packing rules is checked against the DUT on
//            every cycle; directed scenarios add literal expectations.
// Revision : 1.0 - initial release
// ============================================================================
module tb_max_tree_in_packer;

  logic        aclk;
  logic        aresetn;
  logic        aclken;
  logic [5:0]  win_len;
  logic [7:0]  s_axis_data;
  logic        s_axis_last;
  logic        s_axis_valid;
  logic        s_axis_ready;
  logic [31:0] cmp_in;
  logic        cmp_in_vld;
  logic        cmp_in_last;
  logic [15:0] vec_cnt;

  int n_vec = 0;
  int n_err = 0;

  max_tree_in_packer #(
    .cmp_input_n      (4),
    .cmp_width        (8),
    .simulation_delay (1)
  ) dut (
    .aclk         (aclk),
    .aresetn      (aresetn),
    .aclken       (aclken),
    .win_len      (win_len),
    .s_axis_data  (s_axis_data),
    .s_axis_last  (s_axis_last),
    .s_axis_valid (s_axis_valid),
    .s_axis_ready (s_axis_ready),
    .cmp_in       (cmp_in),
    .cmp_in_vld   (cmp_in_vld),
    .cmp_in_last  (cmp_in_last),
    .vec_cnt      (vec_cnt)
  );

  initial aclk = 1'b0;
  always #5 aclk = ~aclk;

  task automatic chk(input string name, input logic [63:0] act,
                     input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // --------------------------------------------------------------------------
  // Model: the current window is a queue of accepted elements; a vector is
  // emitted when the queue reaches the window length or a last beat arrives.
  // --------------------------------------------------------------------------
  logic [7:0]  m_q[$];
  int          m_len  = 4;
  logic [31:0] m_vec;
  logic        m_vld;
  logic        m_last;
  logic [15:0] m_cnt;
  bit          m_init = 1'b0;

  initial begin
    forever begin
      @(posedge aclk);
      if (!aresetn) begin
        m_q.delete();
        m_vld  = 1'b0;
        m_last = 1'b0;
        m_cnt  = 16'd0;
        m_vec  = {4{8'h80}};
        m_init = 1'b1;
      end else if (aclken) begin
        m_vld  = 1'b0;
        m_last = 1'b0;
        if (s_axis_valid) begin
          if (m_q.size() == 0)
            m_len = ((win_len == 6'd0) || (win_len > 6'd4)) ? 4 : int'(win_len);
          m_q.push_back(s_axis_data);
          if ((m_q.size() == m_len) || s_axis_last) begin
            for (int k = 0; k < 4; k++)
              m_vec[k*8 +: 8] = (k < m_q.size()) ? m_q[k] : 8'h80;
            m_vld  = 1'b1;
            m_last = s_axis_last;
            m_cnt  = m_cnt + 16'd1;
            m_q.delete();
          end
        end
      end
    end
  end

  // Per-cycle comparison, on the falling edge away from the active edge.
  always @(negedge aclk) begin
    if (m_init) begin
      chk("model_vld",   64'(cmp_in_vld),   64'(m_vld));
      chk("model_last",  64'(cmp_in_last),  64'(m_last));
      chk("model_cnt",   64'(vec_cnt),      64'(m_cnt));
      chk("model_vec",   64'(cmp_in),       64'(m_vec));
      chk("model_ready", 64'(s_axis_ready), 64'(aclken));
    end
  end

  // --------------------------------------------------------------------------
  // Stimulus helpers
  // --------------------------------------------------------------------------
  task automatic send(input logic [7:0] d, input logic l);
    s_axis_valid = 1'b1;
    s_axis_data  = d;
    s_axis_last  = l;
    @(posedge aclk);
    #1;
    s_axis_valid = 1'b0;
    s_axis_last  = 1'b0;
  endtask

  task automatic chk_out(input string name, input logic [31:0] v,
                         input logic l, input logic [15:0] c);
    chk({name, "_vld"},  64'(cmp_in_vld),  64'(1'b1));
    chk({name, "_vec"},  64'(cmp_in),      64'(v));
    chk({name, "_last"}, 64'(cmp_in_last), 64'(l));
    chk({name, "_cnt"},  64'(vec_cnt),     64'(c));
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge aclk);
    #1;
  endtask

  initial begin
    aresetn      = 1'b0;
    aclken       = 1'b1;
    win_len      = 6'd4;
    s_axis_valid = 1'b0;
    s_axis_data  = 8'h00;
    s_axis_last  = 1'b0;
    idle(2);
    chk("rst_vld",  64'(cmp_in_vld),  64'(1'b0));
    chk("rst_last", 64'(cmp_in_last), 64'(1'b0));
    chk("rst_cnt",  64'(vec_cnt),     64'(16'd0));
    chk("rst_vec",  64'(cmp_in),      64'(32'h80808080));
    aresetn = 1'b1;
    idle(1);

    // 1: full window of four
    send(8'd3, 0); send(8'hFB, 0); send(8'd7, 0); send(8'd1, 0);
    chk_out("s1", 32'h0107FB03, 1'b0, 16'd1);
    idle(1);
    chk("s1_vld_drop", 64'(cmp_in_vld), 64'(1'b0));

    // 2: early close by last, then a full window
    send(8'd10, 0); send(8'd20, 1);
    chk_out("s2a", 32'h8080140A, 1'b1, 16'd2);
    send(8'd1, 0); send(8'd2, 0); send(8'd3, 0); send(8'd4, 0);
    chk_out("s2b", 32'h04030201, 1'b0, 16'd3);
    idle(1);

    // 3: window of three, back to back
    win_len = 6'd3;
    send(8'd1, 0); send(8'd2, 0); send(8'd3, 0);
    chk_out("s3a", 32'h80030201, 1'b0, 16'd4);
    send(8'd4, 0); send(8'd5, 0); send(8'd6, 0);
    chk_out("s3b", 32'h80060504, 1'b0, 16'd5);
    idle(1);
    chk("s3_vld_drop", 64'(cmp_in_vld), 64'(1'b0));

    // 4: stall with a pending vector and a beat held across the stall
    win_len = 6'd4;
    send(8'd3, 0); send(8'hFB, 0); send(8'd7, 0); send(8'd1, 0);
    chk_out("s4a", 32'h0107FB03, 1'b0, 16'd6);
    aclken       = 1'b0;
    s_axis_valid = 1'b1;
    s_axis_data  = 8'd5;
    for (int i = 0; i < 3; i++) begin
      idle(1);
      chk("s4_stall_vld",   64'(cmp_in_vld),   64'(1'b1));
      chk("s4_stall_ready", 64'(s_axis_ready), 64'(1'b0));
    end
    aclken = 1'b1;
    idle(1);
    s_axis_valid = 1'b0;
    chk("s4_vld_clear", 64'(cmp_in_vld), 64'(1'b0));
    send(8'd6, 0); send(8'd7, 0); send(8'd8, 0);
    chk_out("s4b", 32'h08070605, 1'b0, 16'd7);
    idle(1);

    // 5: reset mid-vector with a beat presented during reset
    send(8'd9, 0); send(8'd8, 0);
    aresetn      = 1'b0;
    s_axis_valid = 1'b1;
    s_axis_data  = 8'h55;
    idle(1);
    aresetn      = 1'b1;
    s_axis_valid = 1'b0;
    chk("s5_rst_vld", 64'(cmp_in_vld), 64'(1'b0));
    chk("s5_rst_cnt", 64'(vec_cnt),    64'(16'd0));
    chk("s5_rst_vec", 64'(cmp_in),     64'(32'h80808080));
    send(8'd1, 0); send(8'd2, 0); send(8'd3, 0); send(8'd4, 0);
    chk_out("s5", 32'h04030201, 1'b0, 16'd1);
    idle(1);

    // 6: clamped lengths and a mid-vector win_len change
    win_len = 6'd0;
    send(8'd1, 0); send(8'd2, 0); send(8'd3, 0); send(8'd4, 0);
    chk_out("s6a", 32'h04030201, 1'b0, 16'd2);
    win_len = 6'd9;
    send(8'd5, 0); send(8'd6, 0); send(8'd7, 0); send(8'd8, 0);
    chk_out("s6b", 32'h08070605, 1'b0, 16'd3);
    win_len = 6'd4;
    send(8'd1, 0);
    win_len = 6'd2;
    send(8'd2, 0);
    chk("s6_no_early", 64'(cmp_in_vld), 64'(1'b0));
    send(8'd3, 0); send(8'd4, 0);
    chk_out("s6c", 32'h04030201, 1'b0, 16'd4);
    send(8'd5, 0); send(8'd6, 0);
    chk_out("s6d", 32'h80800605, 1'b0, 16'd5);

    // 7: single-element windows
    win_len = 6'd1;
    send(8'h11, 0);
    chk_out("s7a", 32'h80808011, 1'b0, 16'd6);
    send(8'h22, 1);
    chk_out("s7b", 32'h80808022, 1'b1, 16'd7);
    idle(2);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
`default_nettype wire
